instruction_queue: RTL and testbench
====================================

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous discard of all entries, driven on branch mispredict.
REQ-005 The block SHALL have port enq_valid, input, 1 bit: the decode stage presents a decoded instruction.
REQ-006 The block SHALL have port enq_data, input, instruction_info_reg_t: the decoded instruction from the decode stage.
REQ-007 The block SHALL have port enq_ready, output, 1 bit: the queue can accept an entry this cycle.
REQ-008 The block SHALL have port deq_ready, input, 1 bit: the dispatch/rename stage consumes the head entry.
REQ-009 The block SHALL have port deq_valid, output, 1 bit: the head entry is valid.
REQ-010 The block SHALL have port deq_data, output, instruction_info_reg_t: the head entry.
REQ-011 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of occupied entries.

Function
REQ-012 Storage SHALL be a circular buffer of DEPTH entries of instruction_info_reg_t, with registered head pointer, tail pointer and count.
REQ-013 enq_ready SHALL equal (count != DEPTH), derived from registered state only; it SHALL NOT depend on deq_ready in the same cycle (no full-pop bypass).
REQ-014 deq_valid SHALL equal (count != 0), derived from registered state only.
REQ-015 deq_data SHALL equal mem[head] when deq_valid=1 and all-zeros when deq_valid=0.
REQ-016 A push SHALL occur iff enq_valid && enq_ready && !flush: mem[tail] <= enq_data; tail advances by 1.
REQ-017 A pop SHALL occur iff deq_valid && deq_ready && !flush: head advances by 1.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 Count update SHALL be: push only +1, pop only -1, push and pop together unchanged, neither unchanged.
REQ-020 Latency SHALL be a minimum of 1 cycle from enqueue to deq_valid; there is no empty-queue bypass, so a push into an empty queue asserts deq_valid on the following cycle.
REQ-021 Push and pop in the same cycle SHALL both take effect when 0 < count < DEPTH.
REQ-022 With count=0, a simultaneous deq_ready SHALL have no effect; only the push occurs.
REQ-023 With count=DEPTH, enq_valid SHALL be ignored (enq_ready=0), and a pop the same cycle SHALL still occur, giving enq_ready=1 the next cycle.
REQ-024 Flush SHALL have highest priority: at the next edge head=tail=count=0, and any same-cycle push or pop is discarded.
REQ-025 Entries SHALL be returned in strict FIFO order, and enq_data SHALL be stored bit-exact, including pc_curr, pc_next and inst.
REQ-026 Overflow and underflow SHALL be impossible by construction; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-027 While rst=1, head, tail and count SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 During and after reset, the outputs SHALL be enq_ready=1, deq_valid=0, deq_data=0 and count=0.
REQ-029 Storage array contents need not be reset, and no stale entry SHALL be visible on deq_data.
REQ-030 Reset asserted mid-operation SHALL discard all entries identically to flush, but asynchronously.
REQ-031 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-032 The bench SHALL cover fill to full: DEPTH=16, push 16 entries with inst=0..15 and deq_ready=0 -> count=16, enq_ready=0; a 17th push is not stored.
REQ-033 The bench SHALL cover draining: drain the full queue with deq_ready=1 -> deq_data.inst = 0..15 in order on consecutive cycles, then deq_valid=0 and deq_data=0.
REQ-034 The bench SHALL cover simultaneous push/pop: count=5, enq_valid=1 and deq_ready=1 for 20 cycles -> count stays 5, with pointers wrapping past 15 without data corruption.
REQ-035 The bench SHALL cover full plus pop: count=16, deq_ready=1 and enq_valid=1 -> pop only, count=15, enq_ready=1 the next cycle.
REQ-036 The bench SHALL cover flush: count=7, flush=1 with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0; a later push of inst=0xAA appears at the head alone.
REQ-037 The bench SHALL cover async reset: rst asserted between clock edges with count=9 -> count=0, deq_valid=0 and enq_ready=1 before the next edge.

Source files
------------

// File: rtl/instruction_queue.sv
// Decoded-instruction FIFO between decode and dispatch/rename.
// Circular buffer with registered head/tail/count; no empty bypass, no full-pop bypass.
package instruction_queue_pkg;
  typedef struct packed {
    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic [31:0] inst;
  } instruction_info_reg_t;
endpackage

module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enq_valid,
  input  instruction_info_reg_t   enq_data,
  output logic                    enq_ready,
  input  logic                    deq_ready,
  output logic                    deq_valid,
  output instruction_info_reg_t   deq_data,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  instruction_info_reg_t mem [DEPTH];

  // Handshake flags come only from registered count, so ready/valid never
  // combinationally depend on the other side of the queue.
  assign enq_ready = (count_q != FULL);
  assign deq_valid = (count_q != '0);
  assign deq_data  = deq_valid ? mem[head_q] : '0;
  assign count     = count_q;

  assign push = enq_valid && enq_ready && !flush;
  assign pop  = deq_valid && deq_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth lets pointers wrap by natural overflow.
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; deq_data masking keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= enq_data;
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_instruction_queue;
  import instruction_queue_pkg::*;

  localparam int DEPTH = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  enq_valid;
  instruction_info_reg_t enq_data;
  logic                  enq_ready;
  logic                  deq_ready;
  logic                  deq_valid;
  instruction_info_reg_t deq_data;
  logic [4:0]            count;

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data),
    .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  instruction_info_reg_t model_q[$];

  typedef struct {
    logic        fl;
    logic        ev;
    logic        dr;
    logic [31:0] inst;
    int          exp_count;
    logic        exp_dv;
    logic        exp_er;
    logic [31:0] exp_inst;
  } vec_t;

  function automatic instruction_info_reg_t mk(input logic [31:0] inst);
    instruction_info_reg_t r;
    r.pc_curr = 32'h0000_1000 + (inst << 2);
    r.pc_next = r.pc_curr + 32'd4;
    r.inst    = inst;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: flush empties; push if not full; pop if not empty (pre-edge state).
  task automatic drive(input logic fl, input logic ev, input logic dr,
                       input instruction_info_reg_t d);
    bit do_push, do_pop;
    flush = fl; enq_valid = ev; deq_ready = dr; enq_data = d;
    do_push = !fl && ev && (model_q.size() < DEPTH);
    do_pop  = !fl && dr && (model_q.size() > 0);
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    #1;
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
  endtask

  task automatic check_model(input string nm);
    instruction_info_reg_t exp_d;
    exp_d = (model_q.size() > 0) ? model_q[0] : '0;
    chk({nm, ".count"},     96'(count),     96'(model_q.size()));
    chk({nm, ".deq_valid"}, 96'(deq_valid), 96'(model_q.size() != 0));
    chk({nm, ".enq_ready"}, 96'(enq_ready), 96'(model_q.size() != DEPTH));
    chk({nm, ".deq_data"},  96'(deq_data),  96'(exp_d));
  endtask

  task automatic fill_to(input int n, input int base);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, mk(32'(base + i)));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h01, 1, 1'b1, 1'b1, 32'h01}; // first edge after reset; pop on empty ignored
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h02, 2, 1'b1, 1'b1, 32'h01};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h03, 2, 1'b1, 1'b1, 32'h02};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h00, 1, 1'b1, 1'b1, 32'h03};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h00, 1, 1'b1, 1'b1, 32'h03};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h44, 0, 1'b0, 1'b1, 32'h00};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h55, 1, 1'b1, 1'b1, 32'h55};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b0, 1'b1, 32'h00};

    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0; enq_data = '0;
    #2;
    chk("reset.count",     96'(count),     96'(0));
    chk("reset.enq_ready", 96'(enq_ready), 96'(1));
    chk("reset.deq_valid", 96'(deq_valid), 96'(0));
    chk("reset.deq_data",  96'(deq_data),  96'(0));
    #5 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].ev, vecs[i].dr, mk(vecs[i].inst));
      chk($sformatf("vec%0d.count", i),     96'(count),     96'(vecs[i].exp_count));
      chk($sformatf("vec%0d.deq_valid", i), 96'(deq_valid), 96'(vecs[i].exp_dv));
      chk($sformatf("vec%0d.enq_ready", i), 96'(enq_ready), 96'(vecs[i].exp_er));
      chk($sformatf("vec%0d.deq_data", i),  96'(deq_data),
          96'(vecs[i].exp_dv ? mk(vecs[i].exp_inst) : instruction_info_reg_t'('0)));
    end

    // Fill to full, then a 17th push is refused.
    fill_to(DEPTH, 0);
    chk("fill.count",     96'(count),     96'(16));
    chk("fill.enq_ready", 96'(enq_ready), 96'(0));
    drive(1'b0, 1'b1, 1'b0, mk(32'd99));
    chk("overfill.count", 96'(count), 96'(16));
    check_model("overfill");

    // Drain in order on consecutive cycles.
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d.inst", i), 96'(deq_data.inst), 96'(i));
      chk($sformatf("drain%0d.data", i), 96'(deq_data), 96'(mk(32'(i))));
      drive(1'b0, 1'b0, 1'b1, '0);
    end
    chk("drained.deq_valid", 96'(deq_valid), 96'(0));
    chk("drained.deq_data",  96'(deq_data),  96'(0));

    // Full plus pop: only the pop happens.
    fill_to(DEPTH, 0);
    drive(1'b0, 1'b1, 1'b1, mk(32'd77));
    chk("fullpop.count",     96'(count),          96'(15));
    chk("fullpop.enq_ready", 96'(enq_ready),      96'(1));
    chk("fullpop.head",      96'(deq_data.inst),  96'(1));
    check_model("fullpop");

    // Steady push/pop at count 5, wrapping the pointers.
    drive(1'b1, 1'b0, 1'b0, '0);
    fill_to(5, 100);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, mk(32'(200 + i)));
      chk($sformatf("pp%0d.count", i), 96'(count), 96'(5));
      check_model($sformatf("pp%0d", i));
    end
    chk("pp.head", 96'(deq_data.inst), 96'(215));

    // Flush beats a same-cycle push and pop.
    drive(1'b1, 1'b0, 1'b0, '0);
    fill_to(7, 300);
    chk("preflush.count", 96'(count), 96'(7));
    drive(1'b1, 1'b1, 1'b1, mk(32'h33));
    chk("flush.count",     96'(count),     96'(0));
    chk("flush.deq_valid", 96'(deq_valid), 96'(0));
    drive(1'b0, 1'b1, 1'b0, mk(32'hAA));
    chk("postflush.count", 96'(count),    96'(1));
    chk("postflush.data",  96'(deq_data), 96'(mk(32'hAA)));
    drive(1'b0, 1'b0, 1'b1, '0);
    chk("postflush.empty", 96'(deq_valid), 96'(0));

    // Async reset between edges.
    fill_to(9, 400);
    chk("prerst.count", 96'(count), 96'(9));
    #2 rst = 1'b1;
    #1;
    chk("arst.count",     96'(count),     96'(0));
    chk("arst.deq_valid", 96'(deq_valid), 96'(0));
    chk("arst.enq_ready", 96'(enq_ready), 96'(1));
    chk("arst.deq_data",  96'(deq_data),  96'(0));
    model_q.delete();
    #2 rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      instruction_info_reg_t d;
      d.pc_curr = $urandom; d.pc_next = $urandom; d.inst = $urandom;
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 5), d);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
